// File: rtl/pulse_param_loader.sv
// rtl/pulse_param_loader.sv - UART byte-stream decoder that atomically loads pulse generator parameters
module pulse_param_loader #(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter int         TIMEOUT  = 200000,
  parameter int         DONE_LEN = 4
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  p_bl,
  output logic        pu,
  output logic        cp,
  output logic        bl,
  output logic        rxd,
  output logic        chk_err,
  output logic        tmo_err,
  output logic [7:0]  pkt_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DONE_LEN + 1);
  // cnt_q holds cycles elapsed since the last accepted byte; hitting this value without a byte
  // puts tmo_err on the outputs exactly TIMEOUT cycles after that byte.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] cnt_q, cnt_d;

  // Payload bytes 0..7 (per .. p_bl); the flags byte keeps only the three used bits.
  logic [7:0]    shadow_q [8];
  logic [2:0]    flags_q;

  logic          store_en;
  logic          commit;
  logic          chk_fail;
  logic          tmo_hit;

  logic [7:0]    per_q;
  logic [15:0]   p1wid_q;
  logic [15:0]   del_q;
  logic [15:0]   p2wid_q;
  logic [7:0]    p_bl_q;
  logic          pu_q;
  logic          cp_q;
  logic          bl_q;
  logic          chk_err_q;
  logic          tmo_err_q;
  logic [7:0]    pkt_count_q;
  logic          commit_q;
  logic [DW-1:0] done_cnt_q;

  // FSM state, payload index, running checksum and inter-byte timer registers.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode: framing, checksum compare and timeout; a byte always beats the timeout.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    store_en = 1'b0;
    commit   = 1'b0;
    chk_fail = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_valid && (rx_data == HEADER)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          sum_d   = '0;
          cnt_d   = TW'(1);
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          store_en = 1'b1;
          sum_d    = sum_q + rx_data;
          idx_d    = idx_q + 4'd1;
          cnt_d    = TW'(1);
          if (idx_q == 4'd8) begin
            state_d = CHECK;
          end
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      CHECK: begin
        if (rx_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rx_data == sum_q) begin
            commit = 1'b1;
          end else begin
            chk_fail = 1'b1;
          end
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow capture of payload bytes; nothing here reaches the outputs until a commit.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
      end
      flags_q <= '0;
    end else if (store_en) begin
      if (idx_q == 4'd8) begin
        flags_q <= rx_data[2:0];
      end else begin
        shadow_q[idx_q[2:0]] <= rx_data;
      end
    end
  end

  // Parameter outputs and good-packet counter, all updated together on a commit.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      per_q       <= 8'd15;
      p1wid_q     <= 16'd30;
      del_q       <= 16'd200;
      p2wid_q     <= 16'd30;
      p_bl_q      <= 8'd50;
      pu_q        <= 1'b1;
      cp_q        <= 1'b1;
      bl_q        <= 1'b1;
      pkt_count_q <= '0;
    end else if (commit) begin
      per_q       <= shadow_q[0];
      p1wid_q     <= {shadow_q[1], shadow_q[2]};
      del_q       <= {shadow_q[3], shadow_q[4]};
      p2wid_q     <= {shadow_q[5], shadow_q[6]};
      p_bl_q      <= shadow_q[7];
      pu_q        <= flags_q[0];
      cp_q        <= flags_q[1];
      bl_q        <= flags_q[2];
      pkt_count_q <= pkt_count_q + 8'd1;
    end
  end

  // One-cycle error pulses and a delayed commit flag that starts the rxd window.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      chk_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      chk_err_q <= chk_fail;
      tmo_err_q <= tmo_hit;
      commit_q  <= commit;
    end
  end

  // rxd window: starts one cycle after the parameters move, restarts on every new commit.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      done_cnt_q <= '0;
    end else if (commit_q) begin
      done_cnt_q <= DW'(DONE_LEN);
    end else if (done_cnt_q != '0) begin
      done_cnt_q <= done_cnt_q - DW'(1);
    end
  end

  assign per       = per_q;
  assign p1wid     = p1wid_q;
  assign del       = del_q;
  assign p2wid     = p2wid_q;
  assign p_bl      = p_bl_q;
  assign pu        = pu_q;
  assign cp        = cp_q;
  assign bl        = bl_q;
  assign rxd       = (done_cnt_q != '0);
  assign chk_err   = chk_err_q;
  assign tmo_err   = tmo_err_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// tb/tb_pulse_param_loader.sv - scoreboard bench for pulse_param_loader
module tb_pulse_param_loader;

  localparam int TMO  = 3000;
  localparam int DLEN = 4;
  localparam int K_COMMIT = 0;
  localparam int K_CHK    = 1;
  localparam int K_TMO    = 2;
  localparam int K_RST    = 3;
  localparam logic [66:0] DEF_PRM = {8'd15, 16'd30, 16'd200, 16'd30, 8'd50, 3'b111};

  logic        clk_pll = 1'b0;
  logic        reset   = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  per;
  logic [15:0] p1wid;
  logic [15:0] del;
  logic [15:0] p2wid;
  logic [7:0]  p_bl;
  logic        pu;
  logic        cp;
  logic        bl;
  logic        rxd;
  logic        chk_err;
  logic        tmo_err;
  logic [7:0]  pkt_count;

  pulse_param_loader #(.HEADER(8'hA5), .TIMEOUT(TMO), .DONE_LEN(DLEN)) dut (
    .clk_pll(clk_pll), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .p_bl(p_bl),
    .pu(pu), .cp(cp), .bl(bl), .rxd(rxd), .chk_err(chk_err), .tmo_err(tmo_err),
    .pkt_count(pkt_count)
  );

  always #2.5 clk_pll = ~clk_pll;

  int cyc = 0;
  always @(posedge clk_pll) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [66:0] prm;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 1'b0;
  logic [66:0] m_prm = DEF_PRM;
  logic [7:0]  m_cnt = 8'd0;
  int          m_commit_vis = -100;
  bit          m_chk;
  bit          m_tmo;
  bit          m_rxd;
  exp_t        e_pop;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Model-driven monitor: pop events due this cycle, then compare every output.
  always @(negedge clk_pll) begin
    if (mon_en) begin
      m_chk = 1'b0;
      m_tmo = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e_pop = exp_q.pop_front();
        case (e_pop.kind)
          K_COMMIT: begin
            m_prm = e_pop.prm;
            m_cnt = m_cnt + 8'd1;
            m_commit_vis = cyc;
          end
          K_CHK: m_chk = 1'b1;
          K_TMO: m_tmo = 1'b1;
          default: begin
            m_prm = DEF_PRM;
            m_cnt = 8'd0;
            m_commit_vis = -100;
          end
        endcase
      end
      m_rxd = (cyc > m_commit_vis) && (cyc <= m_commit_vis + DLEN);
      check("params", {per, p1wid, del, p2wid, p_bl, pu, cp, bl}, m_prm);
      check("pkt_count", pkt_count, m_cnt);
      check("rxd", rxd, m_rxd);
      check("chk_err", chk_err, m_chk);
      check("tmo_err", tmo_err, m_tmo);
    end
  end

  // Called and returns at a negedge; the byte is valid during cycle n.
  task automatic send_byte(input logic [7:0] b, input int gap, output int n);
    rx_data  = b;
    rx_valid = 1'b1;
    n = cyc;
    @(negedge clk_pll);
    rx_valid = 1'b0;
    repeat (gap - 1) @(negedge clk_pll);
  endtask

  task automatic send_pkt(input logic [71:0] p, input logic [7:0] dchk, input int gap,
                          input int first_gap);
    logic [7:0] s;
    int         n;
    exp_t       e;
    s = 8'd0;
    send_byte(8'hA5, first_gap, n);
    for (int i = 8; i >= 0; i--) begin
      s = s + p[i*8 +: 8];
      send_byte(p[i*8 +: 8], gap, n);
    end
    rx_data  = s + dchk;
    rx_valid = 1'b1;
    e.kind = (dchk == 8'd0) ? K_COMMIT : K_CHK;
    e.cyc  = cyc + 1;
    e.prm  = {p[71:8], p[0], p[1], p[2]};
    exp_q.push_back(e);
    @(negedge clk_pll);
    rx_valid = 1'b0;
    repeat (gap - 1) @(negedge clk_pll);
  endtask

  logic [71:0] pkt_a;
  logic [71:0] pkt_n;
  logic [95:0] rnd;
  exp_t        ev;
  int          nb;

  initial begin
    pkt_a = 72'h20_00_40_01_00_00_80_32_07;
    pkt_n = 72'h20_A5_00_01_00_00_80_32_07;
    repeat (3) @(negedge clk_pll);
    mon_en = 1'b1;
    repeat (2) @(negedge clk_pll);
    reset = 1'b1;
    repeat (4) @(negedge clk_pll);

    // Reference packet, bytes 2000 cycles apart; checksum 1A.
    send_pkt(pkt_a, 8'd0, 2000, 2000);
    repeat (10) @(negedge clk_pll);

    // Same payload with checksum off by one (1B).
    send_pkt(72'h10_00_11_00_12_00_13_14_00, 8'd0, 3, 3);
    send_pkt(pkt_a, 8'd1, 5, 5);
    repeat (10) @(negedge clk_pll);

    // Header plus four payload bytes, then silence.
    send_byte(8'hA5, 1, nb);
    send_byte(8'h55, 1, nb);
    send_byte(8'h66, 1, nb);
    send_byte(8'h77, 1, nb);
    send_byte(8'h88, 1, nb);
    ev.kind = K_TMO;
    ev.cyc  = nb + TMO;
    ev.prm  = '0;
    exp_q.push_back(ev);
    repeat (TMO + 10) @(negedge clk_pll);
    send_pkt(72'h33_12_34_56_78_9A_BC_DE_02, 8'd0, 2, 2);
    repeat (10) @(negedge clk_pll);

    // Longest legal gap: byte arrives on the last cycle before timeout.
    send_pkt(72'h44_00_01_00_02_00_03_04_05, 8'd0, 1, TMO - 1);
    repeat (10) @(negedge clk_pll);

    // Noise then a packet carrying the header value as data.
    send_byte(8'h00, 2, nb);
    send_byte(8'hFF, 2, nb);
    send_byte(8'h13, 2, nb);
    send_pkt(pkt_n, 8'd0, 2, 2);
    repeat (10) @(negedge clk_pll);

    // Reset three bytes into a packet, then the rest of it.
    send_byte(8'hA5, 2, nb);
    send_byte(8'h20, 2, nb);
    send_byte(8'h00, 2, nb);
    reset = 1'b0;
    ev.kind = K_RST;
    ev.cyc  = cyc + 1;
    ev.prm  = '0;
    exp_q.push_back(ev);
    repeat (2) @(negedge clk_pll);
    reset = 1'b1;
    for (int i = 6; i >= 0; i--) send_byte(pkt_a[i*8 +: 8], 2, nb);
    send_byte(8'h1A, 2, nb);
    repeat (10) @(negedge clk_pll);

    // 256 back-to-back random packets wrap the counter to zero.
    for (int k = 0; k < 256; k++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      send_pkt(rnd[71:0], 8'd0, 1, 1);
    end
    repeat (10) @(negedge clk_pll);
    check("pkt_wrap", pkt_count, 8'd0);
    check("queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
